// File: rtl/mips_pc_pkg.sv
// Shared constants and helpers for the MIPS program counter.
// Imported by the PC interface, selector and register.
package mips_pc_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 26;

  localparam logic [PC_W-1:0] PC_RESET = 32'h0;
  localparam logic [PC_W-1:0] PC_INCR  = 32'd4;

  // Word offset from a 16-bit branch immediate
  function automatic logic [PC_W-1:0] br_off(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mips_pc_if.sv
// Control/fetch bundle into and out of the PC.
// master = control side, slave = PC register.
interface mips_pc_if
  import mips_pc_pkg::*;
();

  logic               jump;
  logic               pcsrc;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc;

  modport master (
    output jump,
    output pcsrc,
    output instr,
    input  pc
  );

  modport slave (
    input  jump,
    input  pcsrc,
    input  instr,
    output pc
  );

endinterface

// File: rtl/pc_next.sv
// Combinational next-PC selector.
// Jump has priority over a taken branch.
module pc_next
  import mips_pc_pkg::*;
(
  input  logic [PC_W-1:0]    pc,
  input  logic               jump,
  input  logic               pcsrc,
  input  logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    next_pc
);

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;

  assign pc_plus4 = pc + PC_INCR;
  assign br_tgt   = pc_plus4 + br_off(instr[15:0]);
  assign j_tgt    = {pc_plus4[31:28], instr, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    priority case (1'b1)
      jump:    next_pc = j_tgt;
      pcsrc:   next_pc = br_tgt;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/mips_pc.sv
// Program-counter register for the single-cycle MIPS datapath.
// Loads the selected next PC on every rising edge.
module mips_pc
  import mips_pc_pkg::*;
(
  input logic     clk,
  input logic     reset,
  mips_pc_if.slave bus
);

  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] pc_q;

  pc_next u_next (
    .pc      (pc_q),
    .jump    (bus.jump),
    .pcsrc   (bus.pcsrc),
    .instr   (bus.instr),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset)
      pc_q <= PC_RESET;
    else
      pc_q <= next_pc;
  end

  assign bus.pc = pc_q;

endmodule

// File: tb/tb_mips_pc.sv
// Directed bench for mips_pc.
// Each step drives one edge and checks pc after it.
module tb_mips_pc;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mips_pc_if bus ();

  mips_pc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input string       tag,
    input logic        rst,
    input logic        j,
    input logic        br,
    input logic [25:0] ins,
    input logic [31:0] exp
  );
    reset     = rst;
    bus.jump  = j;
    bus.pcsrc = br;
    bus.instr = ins;
    @(posedge clk);
    #1;
    checks++;
    assert (bus.pc === exp) else begin
      errors++;
      $error("FAIL %s: pc=%h expected %h", tag, bus.pc, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    bus.jump  = 1'b0;
    bus.pcsrc = 1'b0;
    bus.instr = '0;
    #2;

    step("reset",      1, 0, 0, 26'h0,      32'h0000_0000);
    step("idle1",      0, 0, 0, 26'h0,      32'h0000_0004);
    step("idle2",      0, 0, 0, 26'h0,      32'h0000_0008);
    step("idle3",      0, 0, 0, 26'h0,      32'h0000_000C);
    step("br_fwd",     0, 0, 1, 26'h100014, 32'h0000_0060);
    step("idle4",      0, 0, 0, 26'h100014, 32'h0000_0064);
    step("br_back",    0, 0, 1, 26'h00FFFE, 32'h0000_0060);
    step("jump1",      0, 1, 0, 26'h200020, 32'h0080_0080);
    step("jump2",      0, 1, 0, 26'h000038, 32'h0000_00E0);
    step("j_and_br",   0, 1, 1, 26'h000010, 32'h0000_0040);
    step("rst_jump",   1, 1, 0, 26'h200020, 32'h0000_0000);
    step("br_wrap",    0, 0, 1, 26'h00FFFE, 32'hFFFF_FFFC);
    step("seq_wrap",   0, 0, 0, 26'h0,      32'h0000_0000);
    step("idle5",      0, 0, 0, 26'h0,      32'h0000_0004);
    step("idle6",      0, 0, 0, 26'h0,      32'h0000_0008);
    step("idle7",      0, 0, 0, 26'h0,      32'h0000_000C);
    step("rst_mid",    1, 0, 1, 26'h000010, 32'h0000_0000);
    step("restart1",   0, 0, 0, 26'h0,      32'h0000_0004);
    step("restart2",   0, 0, 0, 26'h0,      32'h0000_0008);
    step("br_restart", 0, 0, 1, 26'h000010, 32'h0000_004C);
    step("rst_hi",     1, 0, 0, 26'h0,      32'h0000_0000);
    step("br_to_top",  0, 0, 1, 26'h00FFFE, 32'hFFFF_FFFC);
    step("br_far",     0, 0, 1, 26'h008000, 32'hFFFE_0000);
    step("jump_hinib", 0, 1, 0, 26'h000010, 32'hF000_0040);
    step("br_hinib",   0, 0, 1, 26'h000001, 32'hF000_0048);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
